// File: rtl/timer_counter.sv
// Prescaled timer/counter: up, auto-reload down, one-shot down and
// up/down modes, NUM_CMP compare channels, wrap event and sticky irq.
//
// Ports:
//   clk, resetn     clock and synchronous active-low reset
//   start, stop     run control pulses (stop wins when both are high)
//   mode            0 up, 1 down reload, 2 down one-shot, 3 up/down
//   psc             one count step per psc+1 running cycles
//   load, load_val  asynchronous-to-count load of q (discards a step)
//   reload_val      period/top value
//   cmp_val         channel i at [i*WIDTH +: WIDTH]
//   irq_en, irq_clr bit0 wrap source, bit i+1 compare i; clear pulse
//   q, running      current count and run state
//   wrap_evt        1-cycle pulse aligned with the post-wrap q
//   cmp_match       per-channel 1-cycle pulse aligned with matching q
//   irq             sticky interrupt
module timer_counter #(
   parameter int WIDTH     = 32,
   parameter int PSC_WIDTH = 16,
   parameter int NUM_CMP   = 2
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       start,
   input  logic                       stop,
   input  logic [1:0]                 mode,
   input  logic [PSC_WIDTH-1:0]       psc,
   input  logic                       load,
   input  logic [WIDTH-1:0]           load_val,
   input  logic [WIDTH-1:0]           reload_val,
   input  logic [NUM_CMP*WIDTH-1:0]   cmp_val,
   input  logic [NUM_CMP:0]           irq_en,
   input  logic                       irq_clr,
   output logic [WIDTH-1:0]           q,
   output logic                       running,
   output logic                       wrap_evt,
   output logic [NUM_CMP-1:0]         cmp_match,
   output logic                       irq
);

   typedef enum logic [1:0] {
      M_UP      = 2'd0,
      M_DN_RELD = 2'd1,
      M_DN_ONE  = 2'd2,
      M_UPDN    = 2'd3
   } mode_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [PSC_WIDTH-1:0] psc_cnt;
   logic                 dir_dn;

   logic                 step;
   logic [WIDTH-1:0]     q_step;
   logic                 dir_step;
   logic                 wrap_step;
   logic                 expire;
   logic [NUM_CMP-1:0]   match_step;
   logic                 run_nxt;
   logic                 irq_set;

   // A step is due when the prescaler has counted psc+1 running cycles.
   assign step = running && (psc_cnt == psc);

   // Next count for a step in the currently selected mode.
   always_comb begin
      q_step    = q;
      dir_step  = dir_dn;
      wrap_step = 1'b0;
      expire    = 1'b0;
      unique case (mode_t'(mode))
         M_UP: begin
            if (q == reload_val) begin
               q_step    = '0;
               wrap_step = 1'b1;
            end else begin
               // Above reload_val this rolls through 2^WIDTH-1 to 0
               // silently, since only the equality is a wrap.
               q_step = q + ONE;
            end
         end
         M_DN_RELD: begin
            if (q == '0) begin
               q_step    = reload_val;
               wrap_step = 1'b1;
            end else begin
               q_step = q - ONE;
            end
         end
         M_DN_ONE: begin
            if (q == '0) begin
               wrap_step = 1'b1;
               expire    = 1'b1;
            end else begin
               q_step = q - ONE;
            end
         end
         M_UPDN: begin
            if (!dir_dn) begin
               if (q >= reload_val) begin
                  dir_step = 1'b1;
                  // A zero top value pins the triangle at 0.
                  if (reload_val != '0) q_step = q - ONE;
               end else begin
                  q_step = q + ONE;
               end
            end else begin
               if (q == '0) begin
                  dir_step  = 1'b0;
                  wrap_step = 1'b1;
                  if (reload_val != '0) q_step = ONE;
               end else begin
                  q_step = q - ONE;
               end
            end
         end
      endcase
   end

   // Compare against the value q is about to take on a step.
   always_comb begin
      match_step = '0;
      for (int i = 0; i < NUM_CMP; i++) begin
         match_step[i] = (q_step == cmp_val[i*WIDTH +: WIDTH]);
      end
   end

   // Run state: stop beats start, start is ignored while running,
   // and a one-shot expiry stops the counter on the expiry edge.
   always_comb begin
      run_nxt = running;
      if (stop) begin
         run_nxt = 1'b0;
      end else if (start && !running) begin
         run_nxt = 1'b1;
      end
      if (running && !load && step && expire) begin
         run_nxt = 1'b0;
      end
   end

   assign irq_set = (wrap_evt & irq_en[0])
                  | (|(cmp_match & irq_en[NUM_CMP:1]));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         q         <= '0;
         psc_cnt   <= '0;
         dir_dn    <= 1'b0;
         running   <= 1'b0;
         wrap_evt  <= 1'b0;
         cmp_match <= '0;
         irq       <= 1'b0;
      end else begin
         wrap_evt  <= 1'b0;
         cmp_match <= '0;
         running   <= run_nxt;
         // Set takes priority over a coincident clear.
         irq       <= (irq & ~irq_clr) | irq_set;

         if (start && !stop && !running) begin
            psc_cnt <= '0;
            dir_dn  <= 1'b0;
         end

         if (load) begin
            q       <= load_val;
            psc_cnt <= '0;
            dir_dn  <= 1'b0;
         end else if (running) begin
            if (step) begin
               q         <= q_step;
               dir_dn    <= dir_step;
               psc_cnt   <= '0;
               wrap_evt  <= wrap_step;
               cmp_match <= match_step;
            end else begin
               psc_cnt <= psc_cnt + 1'b1;
            end
         end
      end
   end

endmodule
